// File: rtl/rv32i_pkg.sv
// Shared RV32I-subset definitions: opcodes, ALU/immediate enums, pipeline register layouts.
// Combinational helpers only; no state.
// No flow control: the pipeline never stalls.
package rv32i_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLT = 3'd5
    } alu_op_e;

    typedef enum logic [1:0] {
        IMM_I = 2'd0,
        IMM_S = 2'd1,
        IMM_B = 2'd2,
        IMM_J = 2'd3
    } imm_fmt_e;

    // All-zero value of every stage register decodes as a bubble.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } if_id_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] imm;
        alu_op_e         alu_op;
        logic            alu_src_imm;
        logic            reg_we;
        logic [4:0]      rd;
        logic            mem_re;
        logic            mem_we;
        logic            branch;
        logic            branch_ne;
        logic            jump;
    } id_ex_t;

    typedef struct packed {
        logic [XLEN-1:0] res;
        logic [XLEN-1:0] store_dat;
        logic [4:0]      rd;
        logic            reg_we;
        logic            mem_re;
        logic            mem_we;
    } ex_mem_t;

    typedef struct packed {
        logic [XLEN-1:0] wb_dat;
        logic [4:0]      rd;
        logic            reg_we;
    } mem_wb_t;

    function automatic logic [XLEN-1:0] imm_gen(input logic [31:0] instr, input imm_fmt_e fmt);
        logic [XLEN-1:0] imm;
        case (fmt)
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = {{20{instr[31]}}, instr[31:20]};
        endcase
        return imm;
    endfunction

    function automatic logic [XLEN-1:0] alu(input alu_op_e op, input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
        logic [XLEN-1:0] r;
        case (op)
            ALU_SUB: r = a - b;
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_XOR: r = a ^ b;
            ALU_SLT: r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            default: r = a + b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rv32i_if.sv
// Data-memory port between the MEM stage and the data RAM.
// Write commits on the clock edge; read data is combinational.
// No backpressure: every access completes in its cycle.
interface rv32i_if;
    import rv32i_pkg::*;

    logic            wr_vld;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wr_dat;
    logic [XLEN-1:0] rd_dat;

    modport master (output wr_vld, output addr, output wr_dat, input rd_dat);
    modport slave  (input wr_vld, input addr, input wr_dat, output rd_dat);
endinterface

// File: rtl/data_path.sv
// Five-stage IF/ID/EX/MEM/WB datapath with decode, ALU and branch resolution in EX.
// One instruction per cycle; hazards are left to software (no forwarding, stall or flush).
// Never stalls.
module data_path
    import rv32i_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int IMEM_BYTES = 1024,
    parameter int DMEM_WORDS = 256
) (
    input logic clk,
    input logic rst_n
);
    if_id_t  if_id;
    id_ex_t  id_ex, id_ex_nxt;
    ex_mem_t ex_mem, ex_mem_nxt;
    mem_wb_t mem_wb, mem_wb_nxt;

    logic                  redirect_vld;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic [DATA_WIDTH-1:0] rs1_dat, rs2_dat;
    logic [DATA_WIDTH-1:0] op_b, alu_res;
    logic [6:0]            opcode, funct7;
    logic [2:0]            funct3;
    imm_fmt_e              imm_fmt;

    rv32i_if dmem_bus ();

    // The fetch write port exists only for completeness; programs are preloaded.
    rv32i_fetch #(.IMEM_BYTES(IMEM_BYTES)) instruction_fetch (
        .clk          (clk),
        .rst_n        (rst_n),
        .redirect_vld (redirect_vld),
        .redirect_pc  (redirect_pc),
        .imem_wr_vld  (1'b0),
        .imem_wr_addr ('0),
        .imem_wr_dat  ('0),
        .if_id        (if_id)
    );

    rv32i_regfile register_file (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1_addr (if_id.instr[19:15]),
        .rs2_addr (if_id.instr[24:20]),
        .rs1_dat  (rs1_dat),
        .rs2_dat  (rs2_dat),
        .wr_vld   (mem_wb.reg_we),
        .wr_addr  (mem_wb.rd),
        .wr_dat   (mem_wb.wb_dat)
    );

    rv32i_dmem #(.DMEM_WORDS(DMEM_WORDS)) data_mem (
        .clk (clk),
        .bus (dmem_bus.slave)
    );

    // Decode: anything not explicitly recognised leaves id_ex_nxt as a bubble.
    always_comb begin
        opcode            = if_id.instr[6:0];
        funct3            = if_id.instr[14:12];
        funct7            = if_id.instr[31:25];
        imm_fmt           = IMM_I;
        id_ex_nxt         = '0;
        id_ex_nxt.pc      = if_id.pc;
        id_ex_nxt.rs1_val = rs1_dat;
        id_ex_nxt.rs2_val = rs2_dat;
        id_ex_nxt.rd      = if_id.instr[11:7];
        case (opcode)
            OP_R: begin
                id_ex_nxt.reg_we = 1'b1;
                case ({funct7, funct3})
                    {F7_BASE, F3_ADD}: id_ex_nxt.alu_op = ALU_ADD;
                    {F7_ALT,  F3_ADD}: id_ex_nxt.alu_op = ALU_SUB;
                    {F7_BASE, F3_SLT}: id_ex_nxt.alu_op = ALU_SLT;
                    {F7_BASE, F3_XOR}: id_ex_nxt.alu_op = ALU_XOR;
                    {F7_BASE, F3_OR}:  id_ex_nxt.alu_op = ALU_OR;
                    {F7_BASE, F3_AND}: id_ex_nxt.alu_op = ALU_AND;
                    default:           id_ex_nxt.reg_we = 1'b0;
                endcase
            end
            OP_IMM: begin
                id_ex_nxt.reg_we      = 1'b1;
                id_ex_nxt.alu_src_imm = 1'b1;
                case (funct3)
                    F3_ADD:  id_ex_nxt.alu_op = ALU_ADD;
                    F3_SLT:  id_ex_nxt.alu_op = ALU_SLT;
                    F3_XOR:  id_ex_nxt.alu_op = ALU_XOR;
                    F3_OR:   id_ex_nxt.alu_op = ALU_OR;
                    F3_AND:  id_ex_nxt.alu_op = ALU_AND;
                    default: id_ex_nxt.reg_we = 1'b0;
                endcase
            end
            OP_LOAD: begin
                if (funct3 == F3_LW) begin
                    id_ex_nxt.reg_we      = 1'b1;
                    id_ex_nxt.alu_src_imm = 1'b1;
                    id_ex_nxt.mem_re      = 1'b1;
                end
            end
            OP_STORE: begin
                imm_fmt = IMM_S;
                if (funct3 == F3_SW) begin
                    id_ex_nxt.alu_src_imm = 1'b1;
                    id_ex_nxt.mem_we      = 1'b1;
                end
            end
            OP_BRANCH: begin
                imm_fmt = IMM_B;
                if (funct3 == F3_BEQ) begin
                    id_ex_nxt.branch = 1'b1;
                end else if (funct3 == F3_BNE) begin
                    id_ex_nxt.branch    = 1'b1;
                    id_ex_nxt.branch_ne = 1'b1;
                end
            end
            OP_JAL: begin
                imm_fmt          = IMM_J;
                id_ex_nxt.jump   = 1'b1;
                id_ex_nxt.reg_we = 1'b1;
            end
            default: ;
        endcase
        id_ex_nxt.imm = imm_gen(if_id.instr, imm_fmt);
    end

    // Execute: branch target is relative to the branch's own PC.
    always_comb begin
        op_b         = id_ex.alu_src_imm ? id_ex.imm : id_ex.rs2_val;
        alu_res      = alu(id_ex.alu_op, id_ex.rs1_val, op_b);
        redirect_vld = id_ex.jump |
                       (id_ex.branch & ((id_ex.rs1_val == id_ex.rs2_val) ^ id_ex.branch_ne));
        redirect_pc  = id_ex.pc + id_ex.imm;

        ex_mem_nxt           = '0;
        ex_mem_nxt.res       = id_ex.jump ? id_ex.pc + DATA_WIDTH'(4) : alu_res;
        ex_mem_nxt.store_dat = id_ex.rs2_val;
        ex_mem_nxt.rd        = id_ex.rd;
        ex_mem_nxt.reg_we    = id_ex.reg_we;
        ex_mem_nxt.mem_re    = id_ex.mem_re;
        ex_mem_nxt.mem_we    = id_ex.mem_we;
    end

    assign dmem_bus.addr   = ex_mem.res;
    assign dmem_bus.wr_vld = ex_mem.mem_we;
    assign dmem_bus.wr_dat = ex_mem.store_dat;

    always_comb begin
        mem_wb_nxt        = '0;
        mem_wb_nxt.wb_dat = ex_mem.mem_re ? dmem_bus.rd_dat : ex_mem.res;
        mem_wb_nxt.rd     = ex_mem.rd;
        mem_wb_nxt.reg_we = ex_mem.reg_we;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex  <= '0;
            ex_mem <= '0;
            mem_wb <= '0;
        end else begin
            id_ex  <= id_ex_nxt;
            ex_mem <= ex_mem_nxt;
            mem_wb <= mem_wb_nxt;
        end
    end
endmodule

// File: rtl/rv32i_dmem.sv
// Word-addressed data RAM; byte-offset bits ignored, upper address bits wrap.
// Combinational read, write on the rising edge at the end of MEM.
// Never stalls.
module rv32i_dmem
    import rv32i_pkg::*;
#(
    parameter int DMEM_WORDS = 256
) (
    input logic    clk,
    rv32i_if.slave bus
);
    localparam int IDX_W = $clog2(DMEM_WORDS);

    logic [XLEN-1:0]  mem [DMEM_WORDS];
    logic [IDX_W-1:0] idx;
    logic             unused_addr_bits;

    assign idx              = bus.addr[IDX_W+1:2];
    assign unused_addr_bits = ^{bus.addr[XLEN-1:IDX_W+2], bus.addr[1:0]};
    assign bus.rd_dat       = mem[idx];

    always_ff @(posedge clk) begin
        if (bus.wr_vld) begin
            mem[idx] <= bus.wr_dat;
        end
    end
endmodule

// File: rtl/rv32i_fetch.sv
// Program counter plus byte-indexed instruction memory, feeding the IF/ID register.
// One fetch per cycle; a redirect from EX takes effect on the same edge.
// Never stalls.
module rv32i_fetch
    import rv32i_pkg::*;
#(
    parameter int IMEM_BYTES = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          redirect_vld,
    input  logic [XLEN-1:0]               redirect_pc,
    input  logic                          imem_wr_vld,
    input  logic [$clog2(IMEM_BYTES)-1:0] imem_wr_addr,
    input  logic [31:0]                   imem_wr_dat,
    output if_id_t                        if_id
);
    localparam int IA_W = $clog2(IMEM_BYTES);

    logic [31:0]     instr_mem [IMEM_BYTES];
    logic [XLEN-1:0] pc;

    // No reset on the array so preloaded programs survive reset.
    always_ff @(posedge clk) begin
        if (imem_wr_vld) begin
            instr_mem[imem_wr_addr] <= imem_wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= '0;
            if_id <= '0;
        end else begin
            if_id.pc    <= pc;
            if_id.instr <= instr_mem[pc[IA_W-1:0]];
            pc          <= redirect_vld ? redirect_pc : pc + XLEN'(4);
        end
    end
endmodule

// File: rtl/rv32i_regfile.sv
// 32 x XLEN register file, x0 hard-wired to zero, two read ports and one write port.
// Reads are combinational with write-through from the same-cycle WB write.
// Never stalls.
module rv32i_regfile
    import rv32i_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_dat,
    output logic [XLEN-1:0] rs2_dat,
    input  logic            wr_vld,
    input  logic [4:0]      wr_addr,
    input  logic [XLEN-1:0] wr_dat
);
    logic [XLEN-1:0] regs [32];
    logic            wr_live;

    assign wr_live = wr_vld && (wr_addr != 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[wr_addr] <= wr_dat;
        end
    end

    always_comb begin
        rs1_dat = regs[rs1_addr];
        rs2_dat = regs[rs2_addr];
        if (wr_live && (wr_addr == rs1_addr)) rs1_dat = wr_dat;
        if (wr_live && (wr_addr == rs2_addr)) rs2_dat = wr_dat;
        if (rs1_addr == 5'd0) rs1_dat = '0;
        if (rs2_addr == 5'd0) rs2_dat = '0;
    end
endmodule

// File: rtl/rv32i_cpu_top.sv
// Top of the 5-stage RV32I-subset core; wires clock, reset and sizing into the datapath.
// One instruction per cycle, no external bus; state is observed hierarchically.
// Never stalls.
module rv32i_cpu_top #(
    parameter int DATA_WIDTH = 32,
    parameter int IMEM_BYTES = 1024,
    parameter int DMEM_WORDS = 256
) (
    input logic i_clk,
    input logic i_reset_n
);
    data_path #(
        .DATA_WIDTH (DATA_WIDTH),
        .IMEM_BYTES (IMEM_BYTES),
        .DMEM_WORDS (DMEM_WORDS)
    ) data_path_inst (
        .clk   (i_clk),
        .rst_n (i_reset_n)
    );
endmodule

// File: tb/tb_rv32i_cpu_top.sv
// Program-level bench: loads small programs, queues expected architectural state, compares after each run.
module tb_rv32i_cpu_top;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    rv32i_cpu_top #(
        .DATA_WIDTH (32),
        .IMEM_BYTES (1024),
        .DMEM_WORDS (256)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n)
    );

    typedef struct packed {
        logic        is_mem;
        logic [7:0]  idx;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] watch_pc = 32'hFFFF_FFFF;
    logic        saw_pc   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Encoders written straight from the RV32I instruction formats.
    function automatic logic [31:0] enc_i(input int f3, input int rd, input int rs1, input int imm);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0010011};
    endfunction
    function automatic logic [31:0] enc_r(input int f7, input int f3, input int rd, input int rs1, input int rs2);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_lw(input int rd, input int rs1, input int imm);
        return {imm[11:0], rs1[4:0], 3'b010, rd[4:0], 7'b0000011};
    endfunction
    function automatic logic [31:0] enc_sw(input int rs2, input int rs1, input int imm);
        return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input int f3, input int rs1, input int rs2, input int imm);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_jal(input int rd, input int imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
    endfunction
    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        return enc_i(0, rd, rs1, imm);
    endfunction

    task automatic put(input int addr, input logic [31:0] w);
        dut.data_path_inst.instruction_fetch.instr_mem[addr] = w;
    endtask

    task automatic exp_reg(input int r, input logic [31:0] v);
        exp_t e;
        e.is_mem = 1'b0;
        e.idx    = 8'(r);
        e.val    = v;
        sb.push_back(e);
    endtask

    task automatic exp_mem(input int i, input logic [31:0] v);
        exp_t e;
        e.is_mem = 1'b1;
        e.idx    = 8'(i);
        e.val    = v;
        sb.push_back(e);
    endtask

    task automatic begin_test();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 1024; i++) dut.data_path_inst.instruction_fetch.instr_mem[i] = 32'h0;
        for (int i = 0; i < 256; i++) dut.data_path_inst.data_mem.mem[i] = 32'h0;
        saw_pc   = 1'b0;
        watch_pc = 32'hFFFF_FFFF;
    endtask

    task automatic run_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (dut.data_path_inst.instruction_fetch.pc == watch_pc) saw_pc = 1'b1;
        end
    endtask

    task automatic drain(input string test);
        exp_t        e;
        logic [31:0] got;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.is_mem) got = dut.data_path_inst.data_mem.mem[e.idx];
            else          got = dut.data_path_inst.register_file.regs[e.idx[4:0]];
            check_eq($sformatf("%s %s[%0d]", test, e.is_mem ? "mem" : "x", e.idx), got, e.val);
        end
    endtask

    initial begin
        logic [31:0] w0;
        logic [31:0] regs_or;

        // Reset state and first fetch, then ADDI through the write-through bypass.
        #1 rst_n = 1'b0;
        begin_test();
        regs_or = '0;
        for (int i = 0; i < 32; i++) regs_or |= dut.data_path_inst.register_file.regs[i];
        check_eq("reset pc", dut.data_path_inst.instruction_fetch.pc, 32'h0);
        check_eq("reset regs", regs_or, 32'h0);
        check_eq("reset if_id", dut.data_path_inst.if_id.instr, 32'h0);
        check_eq("reset wb_we", 32'(dut.data_path_inst.mem_wb.reg_we), 32'h0);

        w0 = addi(1, 1, 1);
        put(0, w0);
        put(12, enc_b(0, 1, 2, 60));
        put(24, addi(3, 0, 5));
        put(72, addi(4, 0, 6));
        exp_reg(1, 32'd1);
        exp_reg(3, 32'd5);
        exp_reg(4, 32'd6);
        rst_n = 1'b1;
        check_eq("pc before first edge", dut.data_path_inst.instruction_fetch.pc, 32'h0);
        @(posedge clk);
        #1;
        check_eq("first fetch pc", dut.data_path_inst.instruction_fetch.pc, 32'h4);
        check_eq("first fetch if_pc", dut.data_path_inst.if_id.pc, 32'h0);
        check_eq("first fetch instr", dut.data_path_inst.if_id.instr, w0);
        run_cycles(40);
        drain("bypass");

        // Taken branch with two delay instructions.
        begin_test();
        put(12, enc_b(0, 1, 2, 60));
        put(16, addi(5, 0, 7));
        put(20, addi(6, 0, 9));
        put(24, addi(7, 0, 1));
        put(72, addi(8, 0, 3));
        exp_reg(5, 32'd7);
        exp_reg(6, 32'd9);
        exp_reg(7, 32'd0);
        exp_reg(8, 32'd3);
        rst_n = 1'b1;
        run_cycles(40);
        drain("beq_taken");

        // Asynchronous reset in the middle of a cycle.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async pc", dut.data_path_inst.instruction_fetch.pc, 32'h0);
        check_eq("async x5", dut.data_path_inst.register_file.regs[5], 32'h0);
        check_eq("async x8", dut.data_path_inst.register_file.regs[8], 32'h0);

        // Stores, including an address that wraps past the RAM depth.
        begin_test();
        put(0, addi(30, 0, 30));
        put(4, addi(20, 0, 20));
        put(16, enc_sw(20, 30, -10));
        put(20, enc_sw(20, 0, 0));
        put(24, enc_sw(30, 0, 1030));
        exp_mem(5, 32'd20);
        exp_mem(0, 32'd20);
        exp_mem(1, 32'd30);
        exp_mem(4, 32'd0);
        exp_mem(6, 32'd0);
        rst_n = 1'b1;
        run_cycles(40);
        drain("store");

        // Store / load round trip and a consumer of the loaded value.
        begin_test();
        put(0, addi(3, 0, 2047));
        put(4, addi(2, 0, 2047));
        put(8, addi(6, 0, 566));
        put(16, enc_r(0, 0, 3, 3, 2));
        put(28, enc_r(0, 0, 3, 3, 6));
        put(40, enc_sw(3, 0, 8));
        put(52, enc_lw(4, 0, 8));
        put(64, enc_r(0, 0, 5, 4, 4));
        exp_reg(3, 32'h1234);
        exp_mem(2, 32'h1234);
        exp_reg(4, 32'h1234);
        exp_reg(5, 32'h2468);
        rst_n = 1'b1;
        run_cycles(40);
        drain("lw");

        // Corner cases: x0, SUB wrap, signed compares, JAL link and delay.
        begin_test();
        put(0, addi(0, 0, 5));
        put(4, addi(1, 0, 1));
        put(12, enc_r(0, 0, 15, 0, 0));
        put(16, enc_r(32, 0, 2, 0, 1));
        put(20, enc_i(6, 7, 0, -256));
        put(24, enc_i(4, 8, 1, -1));
        put(28, enc_r(0, 2, 3, 2, 1));
        put(32, enc_i(2, 4, 1, 2));
        put(36, enc_i(2, 5, 2, 0));
        put(40, enc_jal(1, 16));
        put(44, addi(10, 0, 1));
        put(48, addi(11, 0, 2));
        put(52, addi(12, 0, 3));
        put(56, addi(13, 0, 4));
        exp_reg(0, 32'h0);
        exp_reg(15, 32'h0);
        exp_reg(2, 32'hFFFF_FFFF);
        exp_reg(7, 32'hFFFF_FF00);
        exp_reg(8, 32'hFFFF_FFFE);
        exp_reg(3, 32'd1);
        exp_reg(4, 32'd1);
        exp_reg(5, 32'd1);
        exp_reg(1, 32'd44);
        exp_reg(10, 32'd1);
        exp_reg(11, 32'd2);
        exp_reg(12, 32'd0);
        exp_reg(13, 32'd4);
        watch_pc = 32'd56;
        rst_n = 1'b1;
        run_cycles(40);
        check_eq("jal pc 56 seen", 32'(saw_pc), 32'd1);
        drain("corner");

        // Logic ops, BNE taken/not taken, and unsupported encodings as NOPs.
        begin_test();
        put(0, addi(1, 0, 240));
        put(4, addi(2, 0, 60));
        put(16, enc_r(0, 7, 3, 1, 2));
        put(20, enc_r(0, 6, 4, 1, 2));
        put(24, enc_r(0, 4, 5, 1, 2));
        put(28, enc_i(7, 6, 1, -16));
        put(32, enc_b(1, 1, 2, 16));
        put(36, addi(7, 0, 1));
        put(40, addi(8, 0, 1));
        put(44, addi(9, 0, 1));
        put(48, enc_b(1, 3, 3, 100));
        put(52, addi(10, 0, 1));
        put(56, enc_b(0, 1, 2, 12));
        put(60, addi(11, 0, 1));
        put(64, enc_i(1, 12, 1, 1));
        put(68, 32'hFFFF_FFFF);
        put(72, enc_r(1, 0, 13, 1, 2));
        exp_reg(3, 32'h30);
        exp_reg(4, 32'hFC);
        exp_reg(5, 32'hCC);
        exp_reg(6, 32'hF0);
        exp_reg(7, 32'd1);
        exp_reg(8, 32'd1);
        exp_reg(9, 32'd0);
        exp_reg(10, 32'd1);
        exp_reg(11, 32'd1);
        exp_reg(12, 32'd0);
        exp_reg(31, 32'd0);
        exp_reg(13, 32'd0);
        rst_n = 1'b1;
        run_cycles(40);
        drain("logic_bne");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
